// File: rtl/apb_strb_requester_if.sv
// Command/response port and APB4 bus of apb_strb_requester.
// master = requester view, slave = CPU-side driver plus APB completer view.
interface apb_strb_requester_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_strb_requester.sv
// APB4 requester: byte-addressed 1/2/4-byte commands become one or two word-aligned
// strobed transfers. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_strb_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_strb_requester_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state_reg, state_next;
    logic [29:0] word_reg, word_next;
    logic [1:0]  off_reg, off_next;
    logic [1:0]  size_reg, size_next;
    logic        write_reg, write_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [7:0]  mask_reg, mask_next;
    logic        beat_reg, beat_next;
    logic [31:0] acc_reg, acc_next;
    logic        psel_reg, psel_next;
    logic        penable_reg, penable_next;
    logic        pwrite_reg, pwrite_next;
    logic [31:0] paddr_reg, paddr_next;
    logic [31:0] pwdata_reg, pwdata_next;
    logic [3:0]  pstrb_reg, pstrb_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_error_reg, rsp_error_next;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
`endif

    // Byte-lane decode of the incoming command
    logic [7:0] cmd_mask8;
    logic       cmd_split;
    logic       cmd_illegal;

    always_comb begin
        case (bus.cmd_size)
            2'd0:    cmd_mask8 = 8'h01;
            2'd1:    cmd_mask8 = 8'h03;
            default: cmd_mask8 = 8'h0F;
        endcase
        cmd_mask8   = cmd_mask8 << bus.cmd_addr[1:0];
        cmd_split   = |cmd_mask8[7:4];
        cmd_illegal = (bus.cmd_size == 2'd3) || (cmd_split && (&bus.cmd_addr[31:2]));
    end

    // Read result keeps only the requested number of bytes
    logic [2:0]  nbytes;
    logic [31:0] rd_mask;
    assign nbytes = (size_reg == 2'd0) ? 3'd1 : (size_reg == 2'd1) ? 3'd2 : 3'd4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_mask
            assign rd_mask[gi*8 +: 8] = {8{3'(gi) < nbytes}};
        end
    endgenerate

    logic [5:0]  lo_shift;
    logic [5:0]  hi_shift;
    logic [31:0] rd_result;
    assign lo_shift  = {1'b0, off_reg, 3'b000};
    assign hi_shift  = 6'd32 - lo_shift;
    assign rd_result = (beat_reg ? (acc_reg | (bus.PRDATA << hi_shift))
                                 : (bus.PRDATA >> lo_shift)) & rd_mask;

    always_comb begin
        state_next     = state_reg;
        word_next      = word_reg;
        off_next       = off_reg;
        size_next      = size_reg;
        write_next     = write_reg;
        wdata_next     = wdata_reg;
        mask_next      = mask_reg;
        beat_next      = beat_reg;
        acc_next       = acc_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        pstrb_next     = pstrb_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_error_next = rsp_error_reg;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_next   = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    word_next  = bus.cmd_addr[31:2];
                    off_next   = bus.cmd_addr[1:0];
                    size_next  = bus.cmd_size;
                    write_next = bus.cmd_write;
                    wdata_next = bus.cmd_wdata;
                    mask_next  = cmd_mask8;
                    beat_next  = 1'b0;
                    acc_next   = '0;
                    if (cmd_illegal) begin
                        rsp_valid_next = 1'b1;
                        rsp_error_next = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next   = SETUP;
                        psel_next    = 1'b1;
                        penable_next = 1'b0;
                        pwrite_next  = bus.cmd_write;
                        paddr_next   = {bus.cmd_addr[31:2], 2'b00};
                        pwdata_next  = bus.cmd_wdata << {bus.cmd_addr[1:0], 3'b000};
                        pstrb_next   = bus.cmd_write ? cmd_mask8[3:0] : 4'h0;
                    end
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    if (!beat_reg && (|mask_reg[7:4]) && !bus.PSLVERR) begin
                        state_next   = SETUP;
                        penable_next = 1'b0;
                        beat_next    = 1'b1;
                        acc_next     = bus.PRDATA >> lo_shift;
                        paddr_next   = {word_reg + 30'd1, 2'b00};
                        pwdata_next  = wdata_reg >> hi_shift;
                        pstrb_next   = write_reg ? mask_reg[7:4] : 4'h0;
                    end else begin
                        state_next     = IDLE;
                        psel_next      = 1'b0;
                        penable_next   = 1'b0;
                        rsp_valid_next = 1'b1;
                        rsp_error_next = bus.PSLVERR;
                        rsp_rdata_next = (bus.PSLVERR || write_reg) ? 32'h0 : rd_result;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_error_next = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            off_reg       <= '0;
            size_reg      <= '0;
            write_reg     <= 1'b0;
            wdata_reg     <= '0;
            mask_reg      <= '0;
            beat_reg      <= 1'b0;
            acc_reg       <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            word_reg      <= word_next;
            off_reg       <= off_next;
            size_reg      <= size_next;
            write_reg     <= write_next;
            wdata_reg     <= wdata_next;
            mask_reg      <= mask_next;
            beat_reg      <= beat_next;
            acc_reg       <= acc_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            pstrb_reg     <= pstrb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_error_reg <= rsp_error_next;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg   <= tmo_cnt_next;
`endif
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.PSTRB     = pstrb_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_error = rsp_error_reg;
endmodule
